// File: rtl/id_decode_regfile_npc.sv
// Decode stage of the 5-stage MIPS pipeline: field split, 32x32 GRF and next-PC selection.
// Optional GRF_TRACE_EN adds w_pc/trace ports and a printed trace of every committed GRF write.
module id_decode_regfile_npc #(
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] d_pc,
  input  logic [31:0] f_pc,
  input  logic        w_we,
  input  logic [4:0]  w_a3,
  input  logic [31:0] w_wd,
  input  logic        e_fwd_vld,
  input  logic [4:0]  e_a3,
  input  logic [31:0] e_wd,
  input  logic [31:0] epc,
  input  logic        req,
`ifdef GRF_TRACE_EN
  input  logic [31:0] w_pc,
  output logic        trace_we,
  output logic [4:0]  trace_addr,
  output logic [31:0] trace_wdata,
`endif
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [15:0] imm16,
  output logic [25:0] imm26,
  output logic [4:0]  a3,
  output logic        rfwr,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] npc,
  output logic        br,
  output logic        eret,
  output logic        ri
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000, OP_REGIMM = 6'b000001,
                         OP_J       = 6'b000010, OP_JAL    = 6'b000011,
                         OP_BEQ     = 6'b000100, OP_BNE    = 6'b000101,
                         OP_BLEZ    = 6'b000110, OP_BGTZ   = 6'b000111,
                         OP_ADDI    = 6'b001000, OP_ADDIU  = 6'b001001,
                         OP_SLTI    = 6'b001010, OP_SLTIU  = 6'b001011,
                         OP_ANDI    = 6'b001100, OP_ORI    = 6'b001101,
                         OP_XORI    = 6'b001110, OP_LUI    = 6'b001111,
                         OP_COP0    = 6'b010000,
                         OP_LB      = 6'b100000, OP_LH     = 6'b100001,
                         OP_LW      = 6'b100011, OP_LBU    = 6'b100100,
                         OP_LHU     = 6'b100101, OP_SB     = 6'b101000,
                         OP_SH      = 6'b101001, OP_SW     = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000, FN_SRL   = 6'b000010, FN_SRA  = 6'b000011,
                         FN_SLLV = 6'b000100, FN_SRLV  = 6'b000110, FN_SRAV = 6'b000111,
                         FN_JR   = 6'b001000, FN_JALR  = 6'b001001,
                         FN_MFHI = 6'b010000, FN_MTHI  = 6'b010001,
                         FN_MFLO = 6'b010010, FN_MTLO  = 6'b010011,
                         FN_MULT = 6'b011000, FN_MULTU = 6'b011001,
                         FN_DIV  = 6'b011010, FN_DIVU  = 6'b011011,
                         FN_ADD  = 6'b100000, FN_ADDU  = 6'b100001,
                         FN_SUB  = 6'b100010, FN_SUBU  = 6'b100011,
                         FN_AND  = 6'b100100, FN_OR    = 6'b100101,
                         FN_XOR  = 6'b100110, FN_NOR   = 6'b100111,
                         FN_SLT  = 6'b101010, FN_SLTU  = 6'b101011;

  localparam logic [31:0] ERET_WORD = 32'h4200_0018;
  localparam logic [4:0]  CP0_MF = 5'b00000, CP0_MT = 5'b00100;

  typedef enum logic [1:0] {DST_NONE, DST_RD, DST_RT, DST_RA} dst_e;
  typedef enum logic [3:0] {
    FL_SEQ, FL_BEQ, FL_BNE, FL_BLEZ, FL_BGTZ, FL_BLTZ, FL_BGEZ, FL_J, FL_JR
  } flow_e;

  logic [5:0]  opcode, funct;
  dst_e        dst;
  flow_e       flow;
  logic        known;
  logic        is_eret;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign imm16  = instr[15:0];
  assign imm26  = instr[25:0];

  // Anything that falls through every arm leaves known=0 and is reported as reserved.
  always_comb begin
    dst     = DST_NONE;
    flow    = FL_SEQ;
    known   = 1'b0;
    is_eret = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_MFHI, FN_MFLO: begin
            known = 1'b1;
            dst   = DST_RD;
          end
          FN_MTHI, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: known = 1'b1;
          FN_JR: begin
            known = 1'b1;
            flow  = FL_JR;
          end
          FN_JALR: begin
            known = 1'b1;
            dst   = DST_RD;
            flow  = FL_JR;
          end
          default: ;
        endcase
      end
      OP_REGIMM: begin
        if (rt == 5'b00000) begin
          known = 1'b1;
          flow  = FL_BLTZ;
        end else if (rt == 5'b00001) begin
          known = 1'b1;
          flow  = FL_BGEZ;
        end
      end
      OP_J: begin
        known = 1'b1;
        flow  = FL_J;
      end
      OP_JAL: begin
        known = 1'b1;
        flow  = FL_J;
        dst   = DST_RA;
      end
      OP_BEQ:  begin known = 1'b1; flow = FL_BEQ;  end
      OP_BNE:  begin known = 1'b1; flow = FL_BNE;  end
      OP_BLEZ: begin known = 1'b1; flow = FL_BLEZ; end
      OP_BGTZ: begin known = 1'b1; flow = FL_BGTZ; end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        known = 1'b1;
        dst   = DST_RT;
      end
      OP_SB, OP_SH, OP_SW: known = 1'b1;
      OP_COP0: begin
        if (instr == ERET_WORD) begin
          known   = 1'b1;
          is_eret = 1'b1;
        end else if (rs == CP0_MF) begin
          known = 1'b1;
          dst   = DST_RT;
        end else if (rs == CP0_MT) begin
          known = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (dst)
      DST_RD:  a3 = rd;
      DST_RT:  a3 = rt;
      DST_RA:  a3 = 5'd31;
      default: a3 = 5'd0;
    endcase
  end

  assign rfwr = (a3 != 5'd0);
  assign ri   = ~known;
  assign br   = (flow != FL_SEQ);
  assign eret = is_eret;

  // General register file; entry 0 is never written and always reads as zero.
  logic [31:0] regs_q [32];
  logic        wr_en;

  assign wr_en = w_we && (w_a3 != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[w_a3] <= w_wd;
    end
  end

  assign rd1 = (rs == 5'd0) ? 32'd0 : (wr_en && (w_a3 == rs)) ? w_wd : regs_q[rs];
  assign rd2 = (rt == 5'd0) ? 32'd0 : (wr_en && (w_a3 == rt)) ? w_wd : regs_q[rt];

`ifdef GRF_TRACE_EN
  assign trace_we    = reset && wr_en;
  assign trace_addr  = w_a3;
  assign trace_wdata = w_wd;

  always @(posedge clk) begin
    if (reset && wr_en) $display("%d@%h: $%d <= %h", $time, w_pc, w_a3, w_wd);
  end
`endif

  // Branch operands take the E-stage result when it is ready; rd1/rd2 themselves do not.
  logic signed [31:0] cmp_rs, cmp_rt;
  logic               taken;

  assign cmp_rs = (e_fwd_vld && (e_a3 == rs) && (rs != 5'd0)) ? e_wd : rd1;
  assign cmp_rt = (e_fwd_vld && (e_a3 == rt) && (rt != 5'd0)) ? e_wd : rd2;

  always_comb begin
    case (flow)
      FL_BEQ:  taken = (cmp_rs == cmp_rt);
      FL_BNE:  taken = (cmp_rs != cmp_rt);
      FL_BLEZ: taken = (cmp_rs <= 32'sd0);
      FL_BGTZ: taken = (cmp_rs >  32'sd0);
      FL_BLTZ: taken = (cmp_rs <  32'sd0);
      FL_BGEZ: taken = (cmp_rs >= 32'sd0);
      default: taken = 1'b0;
    endcase
  end

  logic [31:0] d_pc4, br_tgt, j_tgt;

  assign d_pc4  = d_pc + 32'd4;
  assign br_tgt = d_pc4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_tgt  = {d_pc4[31:28], imm26, 2'b00};

  always_comb begin
    npc = f_pc + 32'd4;
    if (req)                npc = EXC_ENTRY;
    else if (is_eret)       npc = epc;
    else if (taken)         npc = br_tgt;
    else if (flow == FL_J)  npc = j_tgt;
    else if (flow == FL_JR) npc = cmp_rs;
  end

endmodule

// File: tb/tb_id_decode_regfile_npc.sv
// Bench for id_decode_regfile_npc: decode table, directed GRF/NPC sequences and a randomized
// run checked against an encoding-table reference model with its own register array.
module tb_id_decode_regfile_npc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = '0, d_pc = '0, f_pc = '0, w_wd = '0, e_wd = '0, epc = '0;
  logic        w_we = 1'b0, e_fwd_vld = 1'b0, req = 1'b0;
  logic [4:0]  w_a3 = '0, e_a3 = '0;
  logic [4:0]  rs, rt, rd, shamt, a3;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic        rfwr, br, eret, ri;
  logic [31:0] rd1, rd2, npc;

  int n_tests = 0;
  int n_fail  = 0;

  id_decode_regfile_npc dut (
    .clk(clk), .reset(reset), .instr(instr), .d_pc(d_pc), .f_pc(f_pc),
    .w_we(w_we), .w_a3(w_a3), .w_wd(w_wd), .e_fwd_vld(e_fwd_vld), .e_a3(e_a3),
    .e_wd(e_wd), .epc(epc), .req(req), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .imm16(imm16), .imm26(imm26), .a3(a3), .rfwr(rfwr), .rd1(rd1), .rd2(rd2),
    .npc(npc), .br(br), .eret(eret), .ri(ri)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: supported encodings as mask/match records.
  // dst: 0 none, 1 rd, 2 rt, 3 $31. kind: 0 seq,1 beq,2 bne,3 blez,4 bgtz,5 bltz,6 bgez,7 j,8 jr,9 eret
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    int          dst;
    int          kind;
  } enc_t;
  enc_t enc[$];

  function automatic void add_enc(input logic [31:0] m, input logic [31:0] v, input int d, input int k);
    enc_t e;
    e.mask = m; e.match = v; e.dst = d; e.kind = k;
    enc.push_back(e);
  endfunction

  task automatic build_model();
    logic [31:0] R, I, RI;
    logic [5:0] fn_rd [18];
    logic [5:0] fn_nw [6];
    logic [5:0] op_rt [13];
    logic [5:0] op_st [3];
    R = 32'hFC00_003F; I = 32'hFC00_0000; RI = 32'hFC1F_0000;
    fn_rd = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12, 6'h20,
              6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    fn_nw = '{6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B};
    op_rt = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
              6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    op_st = '{6'h28, 6'h29, 6'h2B};
    foreach (fn_rd[i]) add_enc(R, {26'd0, fn_rd[i]}, 1, 0);
    foreach (fn_nw[i]) add_enc(R, {26'd0, fn_nw[i]}, 0, 0);
    add_enc(R, 32'h0000_0008, 0, 8);
    add_enc(R, 32'h0000_0009, 1, 8);
    add_enc(RI, 32'h0400_0000, 0, 5);
    add_enc(RI, 32'h0401_0000, 0, 6);
    add_enc(I, 32'h0800_0000, 0, 7);
    add_enc(I, 32'h0C00_0000, 3, 7);
    add_enc(I, 32'h1000_0000, 0, 1);
    add_enc(I, 32'h1400_0000, 0, 2);
    add_enc(I, 32'h1800_0000, 0, 3);
    add_enc(I, 32'h1C00_0000, 0, 4);
    foreach (op_rt[i]) add_enc(I, {op_rt[i], 26'd0}, 2, 0);
    foreach (op_st[i]) add_enc(I, {op_st[i], 26'd0}, 0, 0);
    add_enc(32'hFFE0_0000, 32'h4000_0000, 2, 0);
    add_enc(32'hFFE0_0000, 32'h4080_0000, 0, 0);
    add_enc(32'hFFFF_FFFF, 32'h4200_0018, 0, 9);
  endtask

  logic [31:0] mdl [32];

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (w_we && w_a3 == a) return w_wd;
    return mdl[a];
  endfunction

  task automatic check_model(input string tag);
    int idx = -1;
    int dst = 0, kind = 0;
    logic [31:0] ea3, a, b, exp_npc;
    logic signed [31:0] off, sa, sb;
    bit tk;
    for (int i = 0; i < enc.size(); i++)
      if (idx < 0 && ((instr & enc[i].mask) == enc[i].match)) idx = i;
    if (idx >= 0) begin dst = enc[idx].dst; kind = enc[idx].kind; end
    ea3 = (dst == 1) ? 32'(instr[15:11]) : (dst == 2) ? 32'(instr[20:16]) : (dst == 3) ? 32'd31 : 32'd0;
    a = (e_fwd_vld && e_a3 == instr[25:21] && instr[25:21] != 0) ? e_wd : mread(instr[25:21]);
    b = (e_fwd_vld && e_a3 == instr[20:16] && instr[20:16] != 0) ? e_wd : mread(instr[20:16]);
    sa = a; sb = b;
    case (kind)
      1: tk = (sa == sb);
      2: tk = (sa != sb);
      3: tk = (sa <= 0);
      4: tk = (sa > 0);
      5: tk = (sa < 0);
      6: tk = (sa >= 0);
      default: tk = 0;
    endcase
    off = $signed(instr[15:0]);
    if (req) exp_npc = 32'h0000_4180;
    else if (kind == 9) exp_npc = epc;
    else if (tk) exp_npc = d_pc + 32'd4 + 32'(off * 4);
    else if (kind == 7) exp_npc = ((d_pc + 32'd4) & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
    else if (kind == 8) exp_npc = a;
    else exp_npc = f_pc + 32'd4;
    chk({tag, " a3"},   32'(a3), ea3);
    chk({tag, " rfwr"}, 32'(rfwr), 32'(ea3 != 0));
    chk({tag, " ri"},   32'(ri), 32'(idx < 0));
    chk({tag, " br"},   32'(br), 32'(kind >= 1 && kind <= 8));
    chk({tag, " eret"}, 32'(eret), 32'(kind == 9));
    chk({tag, " rd1"},  rd1, mread(instr[25:21]));
    chk({tag, " rd2"},  rd2, mread(instr[20:16]));
    chk({tag, " npc"},  npc, exp_npc);
    chk({tag, " imm"},  {rs, rt, imm16}, {instr[25:21], instr[20:16], instr[15:0]});
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    w_we = 1'b1; w_a3 = a; w_wd = d;
    @(posedge clk);
    #1;
    w_we = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [4:0]  a3;
    logic        rfwr, br, ri, eret;
    logic [31:0] npc;
  } vec_t;
  vec_t vt[$];

  function automatic void addv(input string n, input logic [31:0] i, input logic [4:0] x,
                               input logic f, input logic b, input logic r, input logic e,
                               input logic [31:0] p);
    vec_t v;
    v.name = n; v.ins = i; v.a3 = x; v.rfwr = f; v.br = b; v.ri = r; v.eret = e; v.npc = p;
    vt.push_back(v);
  endfunction

  logic [31:0] wd_set [6];

  initial begin
    build_model();
    addv("nop",   32'h0000_0000, 5'd0,  0, 0, 0, 0, 32'h0000_3008);
    addv("add",   32'h0022_1820, 5'd3,  1, 0, 0, 0, 32'h0000_3008);
    addv("addiu", 32'h2405_0010, 5'd5,  1, 0, 0, 0, 32'h0000_3008);
    addv("lw",    32'h8C27_0000, 5'd7,  1, 0, 0, 0, 32'h0000_3008);
    addv("sw",    32'hAC27_0000, 5'd0,  0, 0, 0, 0, 32'h0000_3008);
    addv("lui",   32'h3C09_1234, 5'd9,  1, 0, 0, 0, 32'h0000_3008);
    addv("mult",  32'h0022_0018, 5'd0,  0, 0, 0, 0, 32'h0000_3008);
    addv("jal",   32'h0C00_0C00, 5'd31, 1, 1, 0, 0, 32'h0000_3000);
    addv("jalr",  32'h03E0_2009, 5'd4,  1, 1, 0, 0, 32'h0000_0000);
    addv("jr",    32'h03E0_0008, 5'd0,  0, 1, 0, 0, 32'h0000_0000);
    addv("bgez",  32'h0421_0004, 5'd0,  0, 1, 0, 0, 32'h0000_3014);
    addv("eret",  32'h4200_0018, 5'd0,  0, 0, 0, 1, 32'h0000_5000);
    addv("mfc0",  32'h4006_6000, 5'd6,  1, 0, 0, 0, 32'h0000_3008);
    addv("mtc0",  32'h4086_6000, 5'd0,  0, 0, 0, 0, 32'h0000_3008);
    addv("resv",  32'hFC00_0000, 5'd0,  0, 0, 1, 0, 32'h0000_3008);
    addv("badfn", 32'h0022_1801, 5'd0,  0, 0, 1, 0, 32'h0000_3008);
    addv("badri", 32'h0442_0000, 5'd0,  0, 0, 1, 0, 32'h0000_3008);

    // Reset and empty GRF reads
    #3 reset = 1'b0;
    instr = 32'h00BF_0000;
    #1;
    chk("reset rd1", rd1, 32'd0);
    chk("reset rd2", rd2, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Decode table with an all-zero GRF
    d_pc = 32'h3000; f_pc = 32'h3004; epc = 32'h5000;
    foreach (vt[i]) begin
      instr = vt[i].ins;
      #1;
      chk({vt[i].name, " a3"},   32'(a3),   32'(vt[i].a3));
      chk({vt[i].name, " rfwr"}, 32'(rfwr), 32'(vt[i].rfwr));
      chk({vt[i].name, " br"},   32'(br),   32'(vt[i].br));
      chk({vt[i].name, " ri"},   32'(ri),   32'(vt[i].ri));
      chk({vt[i].name, " eret"}, 32'(eret), 32'(vt[i].eret));
      chk({vt[i].name, " npc"},  npc,       vt[i].npc);
    end

    // Write/readback
    wr(5'd8, 32'h1234);
    instr = 32'h0100_0000;
    #1 chk("readback $8", rd1, 32'h1234);

    // $0 write discarded; same-cycle bypass
    @(negedge clk);
    instr = 32'h0000_0000; w_we = 1'b1; w_a3 = 5'd0; w_wd = 32'hFFFF_FFFF;
    #1 chk("$0 bypass", rd1, 32'd0);
    @(posedge clk); #1;
    chk("$0 after write", rd1, 32'd0);
    @(negedge clk);
    instr = 32'h0120_0000; w_a3 = 5'd9; w_wd = 32'hABCD;
    #1 chk("bypass $9", rd1, 32'hABCD);
    @(posedge clk); #1;
    w_we = 1'b0;
    #1 chk("stored $9", rd1, 32'hABCD);

    // beq taken / not taken
    wr(5'd1, 32'd7);
    wr(5'd2, 32'd7);
    instr = 32'h1022_FFFF; d_pc = 32'h3008; f_pc = 32'h300C;
    #1 chk("beq taken npc", npc, 32'h3008);
    chk("beq br", 32'(br), 32'd1);
    wr(5'd2, 32'd8);
    #1 chk("beq not taken npc", npc, 32'h3010);
    chk("beq nt br", 32'(br), 32'd1);

    // bne using forwarded E value
    instr = 32'h1480_0003;
    #1 chk("bne no fwd npc", npc, 32'h3010);
    e_fwd_vld = 1'b1; e_a3 = 5'd4; e_wd = 32'd1;
    #1 chk("bne fwd npc", npc, 32'h3018);
    chk("bne fwd rd1 unforwarded", rd1, 32'd0);
    e_fwd_vld = 1'b0;

    // jal / jr
    instr = 32'h0C00_0C00; d_pc = 32'h3000;
    #1 chk("jal npc", npc, 32'h3000);
    chk("jal a3", 32'(a3), 32'd31);
    chk("jal rfwr", 32'(rfwr), 32'd1);
    req = 1'b1;
    #1 chk("req npc", npc, 32'h4180);
    req = 1'b0;
    wr(5'd31, 32'h3400);
    instr = 32'h03E0_0008;
    #1 chk("jr npc", npc, 32'h3400);
    instr = 32'h4200_0018; epc = 32'h3050;
    #1 chk("eret npc", npc, 32'h3050);
    chk("eret flag", 32'(eret), 32'd1);
    instr = 32'hFC00_0000;
    #1 chk("ri flag", 32'(ri), 32'd1);
    chk("ri rfwr", 32'(rfwr), 32'd0);
    instr = 32'h0000_0000; f_pc = 32'hFFFF_FFFC;
    #1 chk("wrap npc", npc, 32'h0000_0000);

    // Asynchronous clear between edges, then a write lost under reset
    instr = 32'h0100_0000;
    @(negedge clk); #1;
    reset = 1'b0;
    #1 chk("async clear $8", rd1, 32'd0);
    w_we = 1'b1; w_a3 = 5'd10; w_wd = 32'h55;
    @(posedge clk);
    @(negedge clk);
    w_we = 1'b0; reset = 1'b1; instr = 32'h0140_0000;
    #1 chk("write lost $10", rd1, 32'd0);

    // Randomized run against the reference model
    foreach (mdl[i]) mdl[i] = '0;
    wd_set = '{32'd0, 32'd1, 32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) != 0) begin
        enc_t e;
        e = enc[$urandom_range(0, enc.size() - 1)];
        instr = ($urandom & ~e.mask) | e.match;
        if (e.mask[25:21] == 5'd0) instr[25:21] = 5'($urandom_range(0, 7));
        if (e.mask[20:16] == 5'd0) instr[20:16] = 5'($urandom_range(0, 7));
      end else begin
        instr = $urandom;
      end
      wd_set[5] = $urandom;
      w_we = 1'($urandom); w_a3 = 5'($urandom_range(0, 7));
      w_wd = wd_set[$urandom_range(0, 5)];
      e_fwd_vld = 1'($urandom); e_a3 = 5'($urandom_range(0, 7));
      e_wd = wd_set[$urandom_range(0, 5)];
      req = ($urandom_range(0, 7) == 0);
      d_pc = $urandom; f_pc = $urandom; epc = $urandom;
      #1 check_model("rand");
      @(posedge clk);
      if (w_we && w_a3 != 0) mdl[w_a3] = w_wd;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
